// File: rtl/sp_ram_rd_pkg.sv
// Shared types and constants for the single-port RAM burst reader.
// Optional stride support is selected by SP_RD_STRIDE_EN in the top.
package sp_ram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/sp_rd_skid_fifo.sv
// Two-entry register FIFO that absorbs RAM read data while the consumer stalls.
// Push and pop in the same cycle are legal, including when the FIFO is full.
module sp_rd_skid_fifo
  import sp_ram_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [FIFO_CNT_W-1:0] count_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic                  pop_ok, push_ok;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pop_ok  = pop_i && (count_q != '0);
    push_ok = push_i && (pop_ok || (count_q != FIFO_CNT_W'(FIFO_DEPTH)));
    case ({push_ok, pop_ok})
      2'b10: begin
        if (count_q == '0) head_d = push_data_i;
        else               tail_d = push_data_i;
        count_d = count_q + FIFO_CNT_W'(1);
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - FIFO_CNT_W'(1);
      end
      2'b11: begin
        // occupancy is unchanged; only the entries shift
        if (count_q == FIFO_CNT_W'(1)) begin
          head_d = push_data_i;
        end else begin
          head_d = tail_q;
          tail_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign valid_o = (count_q != '0);
  assign data_o  = head_q;

endmodule

// File: rtl/sp_ram_burst_reader.sv
// Burst read master for a single-port RAM: streams words out on valid/ready.
// Define SP_RD_STRIDE_EN to add cmd_stride (address step); otherwise step is 1.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | issuing RAM reads while FIFO space allows
// DRAIN | all reads issued, waiting for the last word to be accepted
module sp_ram_burst_reader
  import sp_ram_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
`ifdef SP_RD_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] cmd_stride,
`endif
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
  logic [LEN_WIDTH-1:0]  recv_cnt_q, recv_cnt_d;
  logic                  ram_re_q, ram_re_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] stride;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  fifo_valid;
  logic                  pop;
  logic [FIFO_CNT_W:0]   occ_next;
  logic                  can_issue;

`ifdef SP_RD_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    stride_q <= '0;
    else if (cmd_valid && (state_q == IDLE))       stride_q <= cmd_stride;
  end

  assign stride = stride_q;
`else
  assign stride = ADDR_WIDTH'(1);
`endif

  assign pop = fifo_valid && out_ready;

  // FIFO fill once the read now on the RAM pins lands and this cycle's pop is taken;
  // a new read may only be issued if it will still find a free slot.
  assign occ_next  = (FIFO_CNT_W+1)'(fifo_count) + (FIFO_CNT_W+1)'(ram_re_q)
                   - (FIFO_CNT_W+1)'(pop);
  assign can_issue = (occ_next < (FIFO_CNT_W+1)'(FIFO_DEPTH));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ram_addr_d  = ram_addr_q;
    ram_re_d    = 1'b0;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    done_d      = 1'b0;
    if (pop) recv_cnt_d = recv_cnt_q - LEN_WIDTH'(1);
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d      = cmd_addr;
            issue_cnt_d = cmd_len;
            recv_cnt_d  = cmd_len;
            state_d     = RUN;
          end
        end
      end
      RUN: begin
        if ((issue_cnt_q != '0) && can_issue) begin
          ram_re_d    = 1'b1;
          ram_addr_d  = addr_q;
          addr_d      = addr_q + stride;
          issue_cnt_d = issue_cnt_q - LEN_WIDTH'(1);
          if (issue_cnt_q == LEN_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (recv_cnt_q == LEN_WIDTH'(1))) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      ram_addr_q  <= '0;
      ram_re_q    <= 1'b0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ram_addr_q  <= ram_addr_d;
      ram_re_q    <= ram_re_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      done_q      <= done_d;
    end
  end

  sp_rd_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (ram_re_q),
    .push_data_i (ram_q),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .valid_o     (fifo_valid),
    .data_o      (out_data)
  );

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign ram_addr  = ram_addr_q;
  assign ram_re    = ram_re_q;
  assign out_valid = fifo_valid;

endmodule

// File: tb/tb_sp_ram_burst_reader.sv
// Self-checking bench for sp_ram_burst_reader; covers SP_RD_STRIDE_EN when defined.
module tb_sp_ram_burst_reader;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int LW = AW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
`ifdef SP_RD_STRIDE_EN
  logic [AW-1:0] cmd_stride;
`endif
  logic [AW-1:0] ram_addr;
  logic          ram_re;
  logic [DW-1:0] ram_q;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  sp_ram_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
`ifdef SP_RD_STRIDE_EN
    .cmd_stride(cmd_stride),
`endif
    .ram_addr  (ram_addr),
    .ram_re    (ram_re),
    .ram_q     (ram_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  // The reader's registered ram_addr acts as the RAM's address register.
  logic [DW-1:0] mem [64];
  assign ram_q = mem[ram_addr];

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [AW-1:0] stride;
    int            mode;       // 0: ready=1, 1: 1,0,0,1,0,1 pattern, 2: random
    int            exp_first;  // cycles after accept edge to first out_valid (-1: never)
    int            exp_done;   // cycles after accept edge to done (-1: not checked)
  } vec_t;

  vec_t          vecs [8];
  logic [DW-1:0] data_q [$];
  logic [AW-1:0] addr_q [$];
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic logic ready_for(input int mode, input int c);
    logic [5:0] pat;
    pat = 6'b101001;
    if (mode == 0) return 1'b1;
    if (mode == 1) return pat[c % 6];
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push_expect(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                             input logic [AW-1:0] stride);
    logic [AW-1:0] a;
    a = addr;
    for (int i = 0; i < int'(len); i++) begin
      addr_q.push_back(a);
      data_q.push_back({2'b00, a} + 8'h40);
      a = a + stride;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_data"},  int'(out_data), 0);
    chk({tag, "_ram_re"},    int'(ram_re), 0);
    chk({tag, "_ram_addr"},  int'(ram_addr), 0);
    chk({tag, "_done"},      int'(done), 0);
  endtask

  // Scoreboard and FIFO-occupancy model, sampled mid-cycle.
  int            occ_m;
  logic          prev_stall;
  logic [DW-1:0] prev_data;
  initial begin
    occ_m = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        occ_m = 0;
        prev_stall = 1'b0;
      end else begin
        chk("out_valid_vs_occupancy", int'(out_valid), int'(occ_m != 0));
        if (prev_stall) begin
          chk("stall_valid_hold", int'(out_valid), 1);
          chk("stall_data_hold", int'(out_data), int'(prev_data));
        end
        if (ram_re) begin
          chk("fifo_no_overflow", int'((occ_m - int'(out_valid && out_ready) + 1) <= 2), 1);
          if (addr_q.size() == 0) fail_now("unexpected_ram_re");
          else chk("ram_addr", int'(ram_addr), int'(addr_q.pop_front()));
        end
        if (out_valid && out_ready) begin
          if (data_q.size() == 0) fail_now("unexpected_output_word");
          else chk("out_data", int'(out_data), int'(data_q.pop_front()));
        end
        occ_m = occ_m + int'(ram_re) - int'(out_valid && out_ready);
        prev_stall = out_valid && !out_ready;
        prev_data = out_data;
      end
    end
  end

  task automatic run_cmd(input vec_t v, input string tag);
    int first_v, done_at, ndone, nre, waitc;
    @(negedge clk);
    waitc = 0;
    while (cmd_ready !== 1'b1 && waitc < 300) begin
      @(negedge clk);
      waitc++;
    end
    if (cmd_ready !== 1'b1) begin
      fail_now({tag, "_cmd_ready_timeout"});
      return;
    end
    cmd_valid = 1'b1;
    cmd_addr  = v.addr;
    cmd_len   = v.len;
`ifdef SP_RD_STRIDE_EN
    cmd_stride = v.stride;
`endif
    push_expect(v.addr, v.len, v.stride);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    first_v = -1; done_at = -1; ndone = 0; nre = 0;
    for (int c = 0; c < 4 * int'(v.len) + 20; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      out_ready = ready_for(v.mode, c);
      @(negedge clk);
      if (out_valid && first_v < 0) first_v = c;
      if (ram_re) nre++;
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (done_at >= 0 && c >= done_at + 2) break;
    end
    out_ready = 1'b1;
    chk({tag, "_first_valid_cycle"}, first_v, v.exp_first);
    if (v.exp_done >= 0) chk({tag, "_done_cycle"}, done_at, v.exp_done);
    chk({tag, "_done_pulses"}, ndone, 1);
    chk({tag, "_ram_re_count"}, nre, int'(v.len));
    chk({tag, "_words_left"}, data_q.size(), 0);
    chk({tag, "_idle_cmd_ready"}, int'(cmd_ready), 1);
    chk({tag, "_idle_busy"}, int'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int waitc, held, pops, done_at;
    vec_t v;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i) + 8'h40;
    vecs[0] = '{6'd4,  7'd5,  6'd1, 0,  2,  7};
    vecs[1] = '{6'd62, 7'd4,  6'd1, 0,  2,  6};
    vecs[2] = '{6'd10, 7'd6,  6'd1, 1,  2, -1};
    vecs[3] = '{6'd0,  7'd0,  6'd1, 0, -1,  0};
    vecs[4] = '{6'd20, 7'd1,  6'd1, 0,  2,  3};
    vecs[5] = '{6'd0,  7'd64, 6'd1, 0,  2, 66};
    vecs[6] = '{6'd7,  7'd70, 6'd1, 0,  2, 72};
    vecs[7] = '{6'd33, 7'd9,  6'd1, 2,  2, -1};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b1;
`ifdef SP_RD_STRIDE_EN
    cmd_stride = 6'd1;
`endif
    repeat (3) @(posedge clk);
    #2 check_reset_outputs("reset");
    @(posedge clk);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // A second command held during a busy burst waits for IDLE.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 6'd8; cmd_len = 7'd3;
    push_expect(6'd8, 7'd3, 6'd1);
    @(posedge clk);
    #1 cmd_addr = 6'd40; cmd_len = 7'd2;
    push_expect(6'd40, 7'd2, 6'd1);
    held = 0; waitc = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && waitc < 50) begin
      held++; waitc++;
      @(negedge clk);
    end
    chk("held_cmd_wait_cycles", held, 5);
    chk("held_cmd_first_done", int'(done), 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    done_at = -1;
    for (int c = 0; c < 20 && done_at < 0; c++) begin
      if (c > 0) @(posedge clk);
      @(negedge clk);
      if (done) done_at = c;
    end
    chk("held_cmd_done_cycle", done_at, 4);
    chk("held_cmd_words_left", data_q.size(), 0);

    // Reset while the third word of an 8-word burst is on the output.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 6'd16; cmd_len = 7'd8;
    push_expect(6'd16, 7'd8, 6'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    pops = 0; waitc = 0;
    while (pops < 2 && waitc < 50) begin
      @(negedge clk);
      if (out_valid && out_ready) pops++;
      waitc++;
    end
    chk("midburst_pops_before_reset", pops, 2);
    @(posedge clk);
    #2;
    chk("midburst_third_word_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #1 check_reset_outputs("midburst_reset");
    data_q.delete();
    addr_q.delete();
    repeat (2) begin
      @(negedge clk);
      chk("midburst_no_done", int'(done), 0);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    v = '{6'd5, 7'd3, 6'd1, 0, 2, 5};
    run_cmd(v, "after_reset");

`ifdef SP_RD_STRIDE_EN
    v = '{6'd0, 7'd4, 6'd3, 0, 2, 6};
    run_cmd(v, "stride3");
    v = '{6'd9, 7'd3, 6'd0, 0, 2, 5};
    run_cmd(v, "stride0");
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sp_ram_burst_reader.md
Name: sp_ram_burst_reader

Overview:
- Read-side master for the single-port RAM with registered read address and read enable.
- Accepts a burst command (start address, word count).
- Drives the RAM addr/re pins and returns the words in order on a valid/ready stream.
- Sits between the RAM and any consumer that cannot tolerate fixed-latency data, such as a DMA or serializer.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 6, RAM address width; the RAM has 2**ADDR_WIDTH words.
- LEN_WIDTH, ADDR_WIDTH+1, burst length field width; allows a full-memory burst.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  burst command present.
- cmd_ready  out  1  reader idle and able to accept a command.
- cmd_addr  in  ADDR_WIDTH  first word address.
- cmd_len  in  LEN_WIDTH  number of words to read.
- ram_addr  out  ADDR_WIDTH  to RAM addr.
- ram_re  out  1  to RAM re; RAM latches addr on this clk edge.
- ram_q  in  DATA_WIDTH  from RAM q, equal to ram[latched addr].
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_WIDTH  output word.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when the last word is accepted.

Behaviour:
- Reset:
  - All outputs are 0 except cmd_ready=1.
  - FSM goes to IDLE; FIFO is emptied.
  - ram_addr=0; ram_re=0.
- RAM timing:
  - Word requested with ram_re=1 at edge N is sampled from ram_q during cycle N+1 and written into the FIFO at edge N+1.
  - ram_addr and ram_re are registered outputs.
- Command handshake:
  - A command is accepted on cmd_valid & cmd_ready.
  - cmd_ready = (state==IDLE).
  - Commands presented while busy are not accepted; cmd_valid must hold until cmd_ready.
- FSM states:
  - IDLE, on accept: cmd_len==0 gives a done pulse next cycle and stays IDLE. Otherwise load addr, issue_cnt=cmd_len, recv_cnt=cmd_len, then go to RUN.
  - RUN: assert ram_re when issue_cnt>0 and (fifo_count + inflight + 1) <= FIFO_DEPTH. FIFO_DEPTH=2, inflight ∈ {0,1}.
    - Each issue increments the address and decrements issue_cnt.
    - When issue_cnt reaches 0, go to DRAIN.
  - DRAIN: wait until recv_cnt==0 (every word accepted downstream). Then pulse done and go to IDLE.
- Throughput:
  - With out_ready held at 1, one word per cycle after a 2-cycle initial latency from the accept edge to the first out_valid.
  - An N-word burst completes N+2 cycles after accept.
- Output stream:
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - Once asserted, out_valid must not drop and out_data must not change until out_ready is seen.
- Address:
  - Increments modulo 2**ADDR_WIDTH; wraps from 2**ADDR_WIDTH-1 to 0 without error.
  - cmd_len > 2**ADDR_WIDTH is permitted and re-reads wrapped words.
- Backpressure: while out_ready=0 and the FIFO is full, ram_re=0. No word is lost or duplicated.
- Counters:
  - busy = (state != IDLE).
  - recv_cnt decrements on each output handshake.
- Reset mid-burst: everything aborts immediately, with no done pulse. Data in flight is discarded.

Optional Feature:
- Macro SP_RD_STRIDE_EN.
- Defined:
  - Adds input cmd_stride [ADDR_WIDTH-1:0], captured on command accept.
  - Address advances by the stride modulo 2**ADDR_WIDTH.
  - Stride 0 repeats one address cmd_len times.
- Undefined: the port is absent and the stride is fixed at 1.

Decomposition:
- Shared package sp_ram_rd_pkg holds:
  - state enum (IDLE/RUN/DRAIN);
  - FIFO_DEPTH=2 constant;
  - width helper constants.
- One sub-module, sp_rd_skid_fifo:
  - 2-entry register FIFO with push/pop/count;
  - simultaneous push and pop when full is legal.
- The top holds the FSM, counters and RAM drive.

Test Plan:
- RAM preloaded with ram[i]=i+8'h40. Command addr=4, len=5, out_ready=1.
  - Required: data 44,45,46,47,48 on consecutive cycles, first at accept+2.
  - Required: done pulses the cycle after the 48 handshake.
- Command addr=62, len=4, ADDR_WIDTH=6.
  - Required: addresses 62,63,0,1; data 7E,7F,40,41.
- Command len=6 with out_ready toggling 1,0,0,1,0,1…
  - Required: all 6 words in order, none duplicated.
  - Required: ram_re never asserted while the FIFO is full with no pop.
  - Required: out_data stable while stalled.
- Command len=0.
  - Required: done pulse one cycle after accept, no ram_re, out_valid stays 0.
- Second cmd_valid held during an active burst.
  - Required: not accepted until IDLE, then accepted, and runs correctly.
- rst_n asserted at the 3rd word of an 8-word burst.
  - Required: outputs go to reset values asynchronously, with no done.
  - Required: a new command after release streams correctly.
- With SP_RD_STRIDE_EN defined: addr=0, len=4, stride=3.
  - Required: data 40,43,46,49.
